axil_master_arbiter: RTL and testbench
======================================

// Module: axil_master_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port between two simple register-access requesters
//  (e.g. a CPU bridge and a local sequencer) driving axi_peripheral_top's slave port.
//  Round-robin arbitration; one outstanding transaction; FSM sequences AW/W/B or AR/R.
//  Returns data/response to the granted requester as a one-cycle response pulse.
// PARAMETERS
//  ADDR_W  32  address width (req*_addr, M_AXI_AWADDR/ARADDR)
//  DATA_W  32  data width (wdata/rdata); strobe width = DATA_W/8
// PORTS
//  clk            in   1         clock; all logic on rising edge
//  resetn         in   1         synchronous reset, active-low
//  reqN_valid     in   1         (N=0,1) request present; held until reqN_ready
//  reqN_ready     out  1         request accepted this cycle
//  reqN_we        in   1         1=write, 0=read
//  reqN_addr      in   ADDR_W    byte address
//  reqN_wdata     in   DATA_W    write data
//  reqN_wstrb     in   DATA_W/8  write byte strobes
//  rspN_valid     out  1         one-cycle response pulse
//  rspN_rdata     out  DATA_W    read data (0 for writes); valid with rspN_valid
//  rspN_resp      out  2         BRESP/RRESP copy; valid with rspN_valid
//  M_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite master channels; widths ADDR_W/DATA_W; AWPROT=ARPROT=3'b000
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (req0 wins first tie); all valids/readies/rsp* = 0; data regs = 0.
//  States: IDLE, WR (AW+W issue), WR_RESP, RD_ADDR, RD_DATA.
//  IDLE: grant = sole valid requester; both valid -> requester != last_grant.
//   reqG_ready = 1 combinationally in IDLE for the granted requester only; on that edge capture
//   addr/wdata/wstrb/we, set last_grant=G, go WR (we=1) or RD_ADDR (we=0). Never both readies high.
//  WR: AWVALID and WVALID rise together the cycle after accept; each drops independently on its
//   own handshake (AWREADY / WREADY, either order or same cycle); when both done -> WR_RESP.
//  WR_RESP: BREADY=1; on BVALID -> rspG_valid=1 next cycle, rspG_resp=BRESP, rdata=0; -> IDLE.
//  RD_ADDR: ARVALID=1 until ARREADY -> RD_DATA. RD_DATA: RREADY=1; on RVALID capture RDATA/RRESP,
//   rspG_valid=1 next cycle; -> IDLE.
//  Latency: accept -> AW/AR valid 1 cycle; B/R handshake -> rsp pulse 1 cycle; back-to-back
//   request may be accepted in the same cycle rsp pulses (FSM already in IDLE).
//  Address/data outputs stable while corresponding VALID is high (AXI rule); VALID never drops
//   before READY. No timeout: FSM waits indefinitely for slave.
//  SLVERR/DECERR passed through unchanged in rspN_resp; no retry.
//  Requester dropping valid before ready: no grant, no effect. Same requester may re-request immediately.
//  Reset mid-transaction: next edge returns to IDLE, all outputs deasserted; in-flight response lost.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: req0 always wins when both valid (last_grant ignored; req1 may starve).
//  Not defined: round-robin as above.
// TESTING
//  1 req0 write addr=0x04 data=0x0000_00A5 strb=0xF, slave AWREADY=WREADY=1 -> AW/W valid 1 cycle
//    after accept, BRESP=00 -> rsp0_valid pulse, rsp0_resp=00, rsp1_valid never.
//  2 req1 read addr=0x08, slave RDATA=0x1234_5678 after 3-cycle RVALID delay -> rsp1_rdata=0x12345678,
//    rsp1_resp=00, exactly one pulse.
//  3 req0,req1 held valid together for 4 transactions -> grants 0,1,0,1 (round-robin); with
//    ARB_FIXED_PRIO_EN -> 0,0,0,0.
//  4 slave WREADY 2 cycles before AWREADY -> WVALID drops first, AWVALID held with stable addr,
//    single B handshake, single rsp pulse.
//  5 slave BRESP=2'b10 on write -> rsp0_resp=2'b10; next request still accepted normally.
//  6 resetn=0 for 1 cycle while in RD_DATA -> all valids/readies 0 next cycle, no rsp pulse, req0 wins next tie.

Source files
------------

// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: two register-access requesters sharing one AXI4-Lite master port,
// one transaction in flight. Define ARB_FIXED_PRIO_EN to make req0 win every tie.
module axil_master_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic [DATA_W/8-1:0]   req0_wstrb,
  output logic                  rsp0_valid,
  output logic [DATA_W-1:0]     rsp0_rdata,
  output logic [1:0]            rsp0_resp,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  input  logic [DATA_W/8-1:0]   req1_wstrb,
  output logic                  rsp1_valid,
  output logic [DATA_W-1:0]     rsp1_rdata,
  output logic [1:0]            rsp1_resp,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  state_t              state_r;
  logic                last_grant_r;
  logic                grant_r;
  logic                grant_s;
  logic                accept_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [DATA_W/8-1:0] sel_wstrb_s;
  logic                aw_done_s;
  logic                w_done_s;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // Arbitration, request acceptance and selection of the granted requester's fields
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
      grant_s = 1'b0;
`else
      grant_s = ~last_grant_r;
`endif
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    accept_s    = resetn && (state_r == ST_IDLE) && (req0_valid || req1_valid);
    req0_ready  = accept_s && !grant_s;
    req1_ready  = accept_s && grant_s;
    sel_we_s    = grant_s ? req1_we    : req0_we;
    sel_addr_s  = grant_s ? req1_addr  : req0_addr;
    sel_wdata_s = grant_s ? req1_wdata : req0_wdata;
    sel_wstrb_s = grant_s ? req1_wstrb : req0_wstrb;
    // a channel counts as done once its valid is low or is being accepted this cycle
    aw_done_s   = !M_AXI_AWVALID || M_AXI_AWREADY;
    w_done_s    = !M_AXI_WVALID  || M_AXI_WREADY;
  end

  // Transaction sequencer; every AXI and response output is a register of this block
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= 1'b1;
      grant_r       <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp0_rdata    <= '0;
      rsp0_resp     <= 2'b00;
      rsp1_valid    <= 1'b0;
      rsp1_rdata    <= '0;
      rsp1_resp     <= 2'b00;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            grant_r      <= grant_s;
            last_grant_r <= grant_s;
            if (sel_we_s) begin
              M_AXI_AWADDR  <= sel_addr_s;
              M_AXI_WDATA   <= sel_wdata_s;
              M_AXI_WSTRB   <= sel_wstrb_s;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state_r       <= ST_WR;
            end else begin
              M_AXI_ARADDR  <= sel_addr_s;
              M_AXI_ARVALID <= 1'b1;
              state_r       <= ST_RD_ADDR;
            end
          end
        end
        ST_WR: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (aw_done_s && w_done_s) begin
            M_AXI_BREADY <= 1'b1;
            state_r      <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (grant_r) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= '0;
              rsp1_resp  <= M_AXI_BRESP;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= '0;
              rsp0_resp  <= M_AXI_BRESP;
            end
            state_r <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state_r       <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (grant_r) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= M_AXI_RDATA;
              rsp1_resp  <= M_AXI_RRESP;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= M_AXI_RDATA;
              rsp0_resp  <= M_AXI_RRESP;
            end
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Randomized bench for axil_master_arbiter: transaction-level model of arbitration and
// AXI4-Lite sequencing, a delay-programmable slave, and directed scenarios with literal pins.
`timescale 1ns/1ps
module tb_axil_master_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED_M = 1'b1;
`else
  localparam bit FIXED_M = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [3:0]  req0_wstrb, req1_wstrb;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [1:0]  rsp0_resp, rsp1_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 clk = ~clk;

  axil_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_resp(rsp0_resp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_resp(rsp1_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // transaction-level model: who owns the port and which channel steps remain
  bit          out_m, rsp_due, last_m;
  bit          cur_who, cur_we;
  logic [31:0] cur_addr, cur_wdata, cur_rdata_exp;
  logic [3:0]  cur_wstrb;
  logic [1:0]  cur_resp_exp, drv_resp;
  bit          aw_pend, w_pend, ar_pend, b_wait, r_wait;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
  int          k_aw, k_w, k_ar, k_b, k_r, k_resp;
  logic [31:0] mem [16];

  // requesters
  bit          r_act [2];
  bit          r_we [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_wstrb [2];
  bit          rand_mode, rst_now;
  int          p_req, p_drop;

  int          rsp_cnt [2];
  logic [31:0] last_rdata [2];
  logic [1:0]  last_resp [2];
  int          grant_log [$];
  int          b_hs_cnt, aw_hs_cyc, w_hs_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    r_act[i] = 1'b1; r_we[i] = we; r_addr[i] = addr; r_wdata[i] = wdata; r_wstrb[i] = wstrb;
  endtask

  function automatic int pick(input int k);
    return (k < 0) ? int'($urandom_range(0, 3)) : k;
  endfunction

  task automatic drive();
    resetn = !rst_now;
    for (int i = 0; i < 2; i++) begin
      if (rand_mode) begin
        if (!r_act[i]) begin
          if (int'($urandom_range(0, 99)) < p_req)
            set_req(i, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                    $urandom, 4'($urandom_range(0, 15)));
        end else if (int'($urandom_range(0, 99)) < p_drop) begin
          r_act[i] = 1'b0;
        end
      end
    end
    req0_valid = r_act[0]; req0_we = r_we[0]; req0_addr = r_addr[0];
    req0_wdata = r_wdata[0]; req0_wstrb = r_wstrb[0];
    req1_valid = r_act[1]; req1_we = r_we[1]; req1_addr = r_addr[1];
    req1_wdata = r_wdata[1]; req1_wstrb = r_wstrb[1];
    // slave: each ready rises a programmed number of cycles after its valid
    M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
    if (M_AXI_AWVALID) aw_cnt++;
    M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_dly);
    if (M_AXI_WVALID) w_cnt++;
    M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
    if (M_AXI_ARVALID) ar_cnt++;
    M_AXI_BVALID = 1'b0;
    if (out_m && cur_we && !aw_pend && !w_pend && b_wait) begin
      M_AXI_BVALID = (b_cnt >= b_dly);
      b_cnt++;
    end
    M_AXI_RVALID = 1'b0;
    if (out_m && !cur_we && !ar_pend && r_wait) begin
      M_AXI_RVALID = (r_cnt >= r_dly);
      r_cnt++;
    end
    M_AXI_BRESP = drv_resp;
    M_AXI_RRESP = drv_resp;
    M_AXI_RDATA = M_AXI_RVALID ? mem[cur_addr[5:2]] : $urandom;
  endtask

  task automatic check();
    bit g;
    bit any_req;
    g = 1'b0;
    // response pulse is due exactly one cycle after the B/R handshake
    chk("rsp0_valid", rsp0_valid, rsp_due && !cur_who);
    chk("rsp1_valid", rsp1_valid, rsp_due && cur_who);
    if (rsp0_valid) begin rsp_cnt[0]++; last_rdata[0] = rsp0_rdata; last_resp[0] = rsp0_resp; end
    if (rsp1_valid) begin rsp_cnt[1]++; last_rdata[1] = rsp1_rdata; last_resp[1] = rsp1_resp; end
    if (rsp_due) begin
      chk("rsp_rdata", cur_who ? rsp1_rdata : rsp0_rdata, cur_rdata_exp);
      chk("rsp_resp", cur_who ? rsp1_resp : rsp0_resp, cur_resp_exp);
      rsp_due = 1'b0;
      out_m   = 1'b0;
    end
    chk("AWVALID", M_AXI_AWVALID, out_m && aw_pend);
    chk("WVALID", M_AXI_WVALID, out_m && w_pend);
    chk("ARVALID", M_AXI_ARVALID, out_m && ar_pend);
    chk("BREADY", M_AXI_BREADY, out_m && cur_we && !aw_pend && !w_pend && b_wait);
    chk("RREADY", M_AXI_RREADY, out_m && !cur_we && !ar_pend && r_wait);
    chk("PROT", {M_AXI_AWPROT, M_AXI_ARPROT}, 6'd0);
    if (M_AXI_AWVALID) chk("AWADDR", M_AXI_AWADDR, cur_addr);
    if (M_AXI_WVALID) begin
      chk("WDATA", M_AXI_WDATA, cur_wdata);
      chk("WSTRB", M_AXI_WSTRB, cur_wstrb);
    end
    if (M_AXI_ARVALID) chk("ARADDR", M_AXI_ARADDR, cur_addr);
    if (resetn) begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_pend = 1'b0; aw_hs_cyc = cyc; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin w_pend = 1'b0; w_hs_cyc = cyc; end
      if (M_AXI_ARVALID && M_AXI_ARREADY) ar_pend = 1'b0;
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        b_wait = 1'b0; rsp_due = 1'b1; cur_resp_exp = M_AXI_BRESP; cur_rdata_exp = 32'd0;
        b_hs_cnt++;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        r_wait = 1'b0; rsp_due = 1'b1; cur_resp_exp = M_AXI_RRESP;
        cur_rdata_exp = mem[cur_addr[5:2]];
      end
    end
    // arbitration: the port is free unless a transaction is in flight
    any_req = r_act[0] || r_act[1];
    if (r_act[0] && r_act[1]) g = FIXED_M ? 1'b0 : !last_m;
    else g = r_act[1];
    chk("req0_ready", req0_ready, resetn && !out_m && any_req && !g);
    chk("req1_ready", req1_ready, resetn && !out_m && any_req && g);
    if (resetn && !out_m && any_req) begin
      cur_who = g; cur_we = r_we[g]; cur_addr = r_addr[g];
      cur_wdata = r_wdata[g]; cur_wstrb = r_wstrb[g];
      last_m = g; out_m = 1'b1; grant_log.push_back(int'(g));
      aw_pend = cur_we; w_pend = cur_we; b_wait = cur_we;
      ar_pend = !cur_we; r_wait = !cur_we;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_dly = pick(k_aw); w_dly = pick(k_w); ar_dly = pick(k_ar);
      b_dly = pick(k_b); r_dly = pick(k_r);
      drv_resp = (k_resp < 0) ? 2'($urandom_range(0, 3)) : 2'(k_resp);
      if (cur_we)
        for (int b = 0; b < 4; b++)
          if (cur_wstrb[b]) mem[cur_addr[5:2]][8*b +: 8] = cur_wdata[8*b +: 8];
      r_act[g] = 1'b0;
    end
    if (!resetn) begin
      out_m = 1'b0; rsp_due = 1'b0; last_m = 1'b1;
      aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0; b_wait = 1'b0; r_wait = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    drive();
    #1;
    check();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((out_m || r_act[0] || r_act[1]) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, out_m || r_act[0] || r_act[1], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, bh0;
    resetn = 1'b0; rst_now = 1'b1; rand_mode = 1'b0; p_req = 0; p_drop = 0;
    out_m = 1'b0; rsp_due = 1'b0; last_m = 1'b1; cur_who = 1'b0; cur_we = 1'b0;
    cur_addr = '0; cur_wdata = '0; cur_wstrb = '0; cur_rdata_exp = '0; cur_resp_exp = '0;
    drv_resp = 2'b00; aw_pend = 0; w_pend = 0; ar_pend = 0; b_wait = 0; r_wait = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    k_aw = 0; k_w = 0; k_ar = 0; k_b = 0; k_r = 0; k_resp = 0;
    b_hs_cnt = 0; aw_hs_cyc = 0; w_hs_cyc = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    for (int i = 0; i < 2; i++) begin
      r_act[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0;
      rsp_cnt[i] = 0; last_rdata[i] = '0; last_resp[i] = '0;
    end
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0; req0_wstrb = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0; req1_wstrb = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0; M_AXI_BVALID = 0;
    M_AXI_RVALID = 0; M_AXI_BRESP = '0; M_AXI_RRESP = '0; M_AXI_RDATA = '0;
    repeat (2) @(posedge clk);
    rst_now = 1'b0;
    step();
    chk("reset_rsp0_rdata", rsp0_rdata, 32'd0);
    chk("reset_rsp1_resp", rsp1_resp, 2'b00);
    chk("reset_awvalid", M_AXI_AWVALID, 1'b0);

    // 1: req0 write, zero-wait slave, OKAY
    set_req(0, 1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF);
    wait_idle("t1", 50);
    chk("t1_rsp0_count", rsp_cnt[0], 1);
    chk("t1_rsp1_count", rsp_cnt[1], 0);
    chk("t1_rsp0_resp", last_resp[0], 2'b00);
    chk("t1_grant", grant_log[0], 0);

    // 2: req1 read with RVALID three cycles late
    mem[2] = 32'h1234_5678; k_r = 3;
    set_req(1, 1'b0, 32'h0000_0008, 32'd0, 4'h0);
    wait_idle("t2", 50);
    chk("t2_rsp1_count", rsp_cnt[1], 1);
    chk("t2_rsp1_rdata", last_rdata[1], 32'h1234_5678);
    chk("t2_rsp1_resp", last_resp[1], 2'b00);

    // 3: both requesters continuously valid for four grants
    grant_log.delete();
    k_aw = -1; k_w = -1; k_ar = -1; k_b = -1; k_r = -1; k_resp = -1;
    rand_mode = 1'b1; p_req = 100; p_drop = 0;
    n = 0;
    while (grant_log.size() < 4 && n < 200) begin step(); n++; end
    rand_mode = 1'b0; r_act[0] = 1'b0; r_act[1] = 1'b0;
    wait_idle("t3", 50);
    chk("t3_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("t3_grant_order", grant_log[i], FIXED_M ? 0 : (i % 2));

    // 4: WREADY two cycles ahead of AWREADY
    k_aw = 2; k_w = 0; k_ar = 0; k_b = 0; k_r = 0; k_resp = 0;
    c0 = rsp_cnt[0]; bh0 = b_hs_cnt;
    set_req(0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h3);
    wait_idle("t4", 50);
    chk("t4_aw_after_w", aw_hs_cyc - w_hs_cyc, 2);
    chk("t4_b_count", b_hs_cnt - bh0, 1);
    chk("t4_rsp0_count", rsp_cnt[0] - c0, 1);

    // 5: SLVERR passes through, next request still served
    k_aw = 0; k_resp = 2;
    set_req(0, 1'b1, 32'h0000_0014, 32'h5555_5555, 4'hF);
    wait_idle("t5a", 50);
    chk("t5_slverr", last_resp[0], 2'b10);
    k_resp = 0; c0 = rsp_cnt[0];
    set_req(0, 1'b0, 32'h0000_0010, 32'd0, 4'h0);
    wait_idle("t5b", 50);
    chk("t5_next_count", rsp_cnt[0] - c0, 1);
    chk("t5_next_resp", last_resp[0], 2'b00);
    chk("t5_strobed_rdata", last_rdata[0], 32'h0000_F00D);

    // 6: reset while waiting for read data
    k_r = 20;
    set_req(0, 1'b0, 32'h0000_0010, 32'd0, 4'h0);
    n = 0;
    while (!M_AXI_RREADY && n < 20) begin step(); n++; end
    chk("t6_reached_rd_data", M_AXI_RREADY, 1'b1);
    rst_now = 1'b1; r_act[0] = 1'b0; r_act[1] = 1'b0;
    step();
    rst_now = 1'b0; k_r = 0;
    step();
    chk("t6_rready_cleared", M_AXI_RREADY, 1'b0);
    chk("t6_bready_cleared", M_AXI_BREADY, 1'b0);
    c0 = rsp_cnt[0];
    repeat (5) step();
    chk("t6_no_rsp", rsp_cnt[0], c0);
    grant_log.delete();
    set_req(0, 1'b1, 32'h0000_0020, 32'h0000_0001, 4'h1);
    set_req(1, 1'b1, 32'h0000_0024, 32'h0000_0002, 4'h1);
    wait_idle("t6_tie", 80);
    chk("t6_tie_winner", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // random traffic
    k_aw = -1; k_w = -1; k_ar = -1; k_b = -1; k_r = -1; k_resp = -1;
    rand_mode = 1'b1; p_req = 30; p_drop = 5;
    repeat (3000) step();
    rand_mode = 1'b0; r_act[0] = 1'b0; r_act[1] = 1'b0;
    wait_idle("final", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
